// File: rtl/bf_tape.sv
// bf_tape: addressable tape of cells with a movable cursor, in-place
// add/write commands and a one-cell-per-cycle clear sweep.
module bf_tape #(
  parameter int unsigned DATA_ADDR_SIZE = 8,
  parameter int unsigned CELL_WIDTH     = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid,
  input  logic [2:0]                cmd_op,
  input  logic [CELL_WIDTH-1:0]     cmd_arg,
  output logic                      ready,
  output logic [DATA_ADDR_SIZE-1:0] cursor,
  output logic [CELL_WIDTH-1:0]     read_val,
  output logic                      is_zero,
  output logic                      clearing,
  output logic                      clear_done
);

  localparam int unsigned DEPTH = 1 << DATA_ADDR_SIZE;
  // Sign extension width for MOVE deltas when the address is wider than a cell
  localparam int unsigned EXT_W = (DATA_ADDR_SIZE > CELL_WIDTH) ? DATA_ADDR_SIZE : CELL_WIDTH;

  localparam logic [DATA_ADDR_SIZE-1:0] LAST_ADDR = {DATA_ADDR_SIZE{1'b1}};

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;
  localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_SWEEP : ST_IDLE;

  localparam logic [2:0] OP_MOVE  = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_WRITE = 3'd3;
  localparam logic [2:0] OP_CLEAR = 3'd4;

  logic [0:0]                state_q, state_d;
  logic [DATA_ADDR_SIZE-1:0] cursor_q, cursor_d;
  logic [DATA_ADDR_SIZE-1:0] sweep_addr_q, sweep_addr_d;
  logic                      clear_done_q, clear_done_d;

  logic [CELL_WIDTH-1:0]     mem_q [DEPTH];
  logic                      mem_we_d;
  logic [DATA_ADDR_SIZE-1:0] mem_waddr_d;
  logic [CELL_WIDTH-1:0]     mem_wdata_d;
  logic [CELL_WIDTH-1:0]     cell_cur;

  assign cell_cur = mem_q[cursor_q];

  // Next-state, cursor and tape write decode for both FSM states
  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    sweep_addr_d = sweep_addr_q;
    clear_done_d = 1'b0;
    mem_we_d     = 1'b0;
    mem_waddr_d  = cursor_q;
    mem_wdata_d  = cell_cur;
    case (state_q)
      ST_SWEEP: begin
        mem_we_d     = 1'b1;
        mem_waddr_d  = sweep_addr_q;
        mem_wdata_d  = '0;
        sweep_addr_d = sweep_addr_q + DATA_ADDR_SIZE'(1);
        if (sweep_addr_q == LAST_ADDR) begin
          state_d      = ST_IDLE;
          clear_done_d = 1'b1;
        end
      end
      default: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_MOVE: cursor_d = cursor_q + DATA_ADDR_SIZE'(EXT_W'($signed(cmd_arg)));
            OP_ADD: begin
              mem_we_d    = 1'b1;
              mem_wdata_d = cell_cur + cmd_arg;
            end
            OP_WRITE: begin
              mem_we_d    = 1'b1;
              mem_wdata_d = cmd_arg;
            end
            OP_CLEAR: begin
              state_d      = ST_SWEEP;
              sweep_addr_d = '0;
              cursor_d     = '0;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RESET;
      cursor_q     <= '0;
      sweep_addr_q <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      sweep_addr_q <= sweep_addr_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Tape storage: not reset, zeroed only by the sweep
  always_ff @(posedge clock) begin
    if (mem_we_d) mem_q[mem_waddr_d] <= mem_wdata_d;
  end

  assign ready      = (state_q == ST_IDLE);
  assign clearing   = (state_q == ST_SWEEP);
  assign cursor     = cursor_q;
  assign clear_done = clear_done_q;
  assign read_val   = clearing ? '0 : cell_cur;
  assign is_zero    = (read_val == '0);

endmodule

// File: tb/tb_bf_tape.sv
// Self-checking bench for bf_tape (depth 16, 8-bit cells, clear on reset).
module tb_bf_tape;

  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 8;
  localparam int          DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [2:0]    cmd_op;
  logic [CW-1:0] cmd_arg;
  logic          ready;
  logic [AW-1:0] cursor;
  logic [CW-1:0] read_val;
  logic          is_zero;
  logic          clearing;
  logic          clear_done;

  bf_tape #(.DATA_ADDR_SIZE(AW), .CELL_WIDTH(CW), .CLEAR_ON_RESET(1'b1)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .ready(ready), .cursor(cursor), .read_val(read_val),
    .is_zero(is_zero), .clearing(clearing), .clear_done(clear_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: tape as an int array, sweep as a count of cells left
  int m_mem [DEPTH];
  int m_cursor;
  int m_left;
  bit m_done;

  typedef struct {
    logic [2:0] op;
    logic [7:0] arg;
    int         exp_read;
    int         exp_cursor;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int d;
    if (m_left > 0) begin
      m_mem[DEPTH - m_left] = 0;
      m_left--;
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (cmd_valid) begin
        d = int'($signed(cmd_arg));
        case (int'(cmd_op))
          1: m_cursor = (((m_cursor + d) % DEPTH) + DEPTH) % DEPTH;
          2: m_mem[m_cursor] = (m_mem[m_cursor] + int'(cmd_arg)) % 256;
          3: m_mem[m_cursor] = int'(cmd_arg);
          4: begin m_left = DEPTH; m_cursor = 0; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    bit busy;
    int exp_rd;
    busy   = (m_left > 0);
    exp_rd = busy ? 0 : m_mem[m_cursor];
    chk({tag, ".ready"}, int'(ready), int'(!busy));
    chk({tag, ".clearing"}, int'(clearing), int'(busy));
    chk({tag, ".cursor"}, int'(cursor), m_cursor);
    chk({tag, ".read_val"}, int'(read_val), exp_rd);
    chk({tag, ".is_zero"}, int'(is_zero), int'(exp_rd == 0));
    chk({tag, ".clear_done"}, int'(clear_done), int'(m_done));
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic drv(input string tag, input bit v, input logic [2:0] op, input logic [7:0] arg);
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = arg;
    step(tag);
  endtask

  // Reset pulse starting just after a rising edge; model follows reset values
  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    m_left = DEPTH; m_cursor = 0; m_done = 1'b0;
    #1;
    chk({tag, ".rst_clearing"}, int'(clearing), 1);
    chk({tag, ".rst_ready"}, int'(ready), 0);
    chk({tag, ".rst_cursor"}, int'(cursor), 0);
    chk({tag, ".rst_clear_done"}, int'(clear_done), 0);
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // Count sweep cycles (bounded) and clear_done pulses seen during them
  task automatic run_sweep(input string tag, input bit v, input logic [2:0] op, input logic [7:0] arg);
    int n;
    int pulses;
    n = 0; pulses = 0;
    while (clearing === 1'b1 && n < 40) begin
      if (clear_done === 1'b1) pulses++;
      drv(tag, v, op, arg);
      n++;
    end
    chk({tag, ".sweep_len"}, n, DEPTH);
    chk({tag, ".early_done"}, pulses, 0);
    chk({tag, ".done_pulse"}, int'(clear_done), 1);
    chk({tag, ".end_cursor"}, int'(cursor), 0);
  endtask

  task automatic scan_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      drv(tag, 1'b1, 3'd1, 8'h01);
      chk({tag, ".cell0"}, int'(read_val), 0);
    end
  endtask

  vec_t vecs [13];

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 8'h00;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    m_cursor = 0; m_left = 0; m_done = 1'b0;

    vecs[0]  = '{3'd3, 8'h7F, 8'h7F, 0};
    vecs[1]  = '{3'd2, 8'h01, 8'h80, 0};
    vecs[2]  = '{3'd2, 8'hFE, 8'h7E, 0};
    vecs[3]  = '{3'd1, 8'hFF, 8'h00, 15};
    vecs[4]  = '{3'd1, 8'h01, 8'h7E, 0};
    vecs[5]  = '{3'd3, 8'hFF, 8'hFF, 0};
    vecs[6]  = '{3'd2, 8'h01, 8'h00, 0};
    vecs[7]  = '{3'd2, 8'hFF, 8'hFF, 0};
    vecs[8]  = '{3'd0, 8'h55, 8'hFF, 0};
    vecs[9]  = '{3'd5, 8'h03, 8'hFF, 0};
    vecs[10] = '{3'd7, 8'h09, 8'hFF, 0};
    vecs[11] = '{3'd1, 8'h13, 8'h00, 3};
    vecs[12] = '{3'd1, 8'hF0, 8'h00, 3};

    // Power-on sweep
    do_reset("por");
    run_sweep("por", 1'b0, 3'd0, 8'h00);
    drv("por_after", 1'b0, 3'd0, 8'h00);
    scan_zero("por_scan");

    // Directed arithmetic / cursor vectors from cursor 0
    for (int i = 0; i < 13; i++) begin
      drv($sformatf("vec%0d", i), 1'b1, vecs[i].op, vecs[i].arg);
      chk($sformatf("vec%0d.tbl_read", i), int'(read_val), vecs[i].exp_read);
      chk($sformatf("vec%0d.tbl_cursor", i), int'(cursor), vecs[i].exp_cursor);
      chk($sformatf("vec%0d.tbl_zero", i), int'(is_zero), int'(vecs[i].exp_read == 0));
    end

    // CLEAR with ADD held during the sweep
    for (int i = 0; i < 6; i++) begin
      drv("fill", 1'b1, 3'd3, 8'($urandom_range(1, 255)));
      drv("fill_mv", 1'b1, 3'd1, 8'h01);
    end
    drv("clr_cmd", 1'b1, 3'd4, 8'h00);
    run_sweep("clr", 1'b1, 3'd2, 8'h05);
    drv("clr_after", 1'b0, 3'd2, 8'h00);
    chk("clr_after.done_low", int'(clear_done), 0);
    scan_zero("clr_scan");

    // Reset during sweep cycle 5 restarts a full sweep
    for (int i = 0; i < DEPTH; i++) begin
      drv("fill2", 1'b1, 3'd3, 8'hA5);
      drv("fill2_mv", 1'b1, 3'd1, 8'h01);
    end
    drv("abort_cmd", 1'b1, 3'd4, 8'h00);
    for (int i = 0; i < 5; i++) drv("abort_sw", 1'b0, 3'd0, 8'h00);
    chk("abort.pre_done", int'(clear_done), 0);
    do_reset("abort");
    run_sweep("restart", 1'b0, 3'd0, 8'h00);
    scan_zero("restart_scan");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (op == 3'd4 && ($urandom % 6) != 0) op = 3'd2;
      drv("rnd", ($urandom % 4) != 0, op, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
